div_unit: RTL and testbench

Iterative radix-2 integer divider for the RV64M divide/remainder group (DIV, DIVU, REM, REMU and the W forms). It sits in the execute stage, directly upstream of the memory-access stage. It computes the 64-bit `result` value that the access stage consumes as its ALU result, and it holds the pipeline through `stall` until that value is valid. It also honours the access stage's own stall, so a finished result is never lost while memory access is blocked.

---
 rtl/div_unit.sv | 225 ++++++++++++++++++++++
 tb/tb_div_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for the RV64M divide/remainder group
// (DIV, DIVU, REM, REMU and their W forms), living in the execute stage.
//
// One quotient bit is produced per cycle. Divide-by-zero and signed overflow bypass the
// iteration and finish in the cycle after start. The result is held in DONE until the
// memory-access stage is free to accept it.
//
// Build option:
//   DIV_EARLY_OUT_EN - when defined, an operation whose dividend magnitude is below the
//                      divisor magnitude skips the iteration (quotient 0, remainder is
//                      the dividend magnitude) and completes in two cycles.

module div_unit #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            ma_stall,
  output logic            stall,
  output logic [XLEN-1:0] result,
  output logic            done
);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFixup,
    StDone
  } state_e;

  // Sign-extend a 32-bit value to the full register width.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN - 32){v[31]}}, v};
  endfunction

  // Zero-extend a 32-bit value to the full register width.
  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    return {{(XLEN - 32){1'b0}}, v};
  endfunction

  state_e          state_q;
  logic [5:0]      cnt_q;
  logic [XLEN-1:0] rem_q;      // partial remainder
  logic [XLEN-1:0] quo_q;      // dividend bits shifting out, quotient bits shifting in
  logic [XLEN-1:0] dvs_q;      // divisor magnitude
  logic            rem_sel_q;  // 1: REM/REMU, 0: DIV/DIVU
  logic            word_q;
  logic            q_neg_q;    // quotient must be negated
  logic            r_neg_q;    // remainder must be negated

  // Operand decode, only meaningful in IDLE while start is high.
  logic            is_signed;
  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] min_val;
  logic            div_zero;
  logic            overflow;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] quo_init;
  logic            early_out;

  // Bring both operands to the active width, then split them into sign and magnitude.
  always_comb begin
    is_signed = ~op[0];
    a_ext     = src1;
    b_ext     = src2;
    min_val   = {1'b1, {(XLEN - 1){1'b0}}};
    if (word) begin
      a_ext   = is_signed ? sext32(src1[31:0]) : zext32(src1[31:0]);
      b_ext   = is_signed ? sext32(src2[31:0]) : zext32(src2[31:0]);
      min_val = sext32(32'h8000_0000);
    end
    a_neg    = is_signed & a_ext[XLEN-1];
    b_neg    = is_signed & b_ext[XLEN-1];
    a_mag    = a_neg ? (~a_ext + 1'b1) : a_ext;
    b_mag    = b_neg ? (~b_ext + 1'b1) : b_ext;
    div_zero = (b_ext == '0);
    overflow = is_signed & (a_ext == min_val) & (b_ext == '1);
    // W dividends are left-aligned so the MSB tap is the same for both widths.
    quo_init = word ? {a_mag[31:0], {(XLEN - 32){1'b0}}} : a_mag;
  end

  // Results that bypass the iteration: divide by zero and signed overflow.
  always_comb begin
    special_res = '0;
    if (div_zero) begin
      if (op[1]) begin
        special_res = word ? sext32(src1[31:0]) : src1;
      end else begin
        special_res = '1;
      end
    end else if (!op[1]) begin
      special_res = a_ext;
    end
  end

`ifdef DIV_EARLY_OUT_EN
  // Dividend smaller than divisor: the quotient is zero and the remainder is the dividend.
  always_comb begin
    early_out = (a_mag < b_mag);
  end
`else
  // Every regular operation runs the full iteration.
  always_comb begin
    early_out = 1'b0;
  end
`endif

  // One restoring step: shift in the next dividend bit and try to subtract the divisor.
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;
  logic            borrow;
  logic [XLEN-1:0] rem_step;
  logic [XLEN-1:0] quo_step;

  always_comb begin
    shifted  = {rem_q, quo_q[XLEN-1]};
    diff     = {1'b0, shifted} - {2'b00, dvs_q};
    borrow   = diff[XLEN+1];
    rem_step = borrow ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    quo_step = {quo_q[XLEN-2:0], ~borrow};
  end

  // Sign correction, quotient/remainder selection and W-form sign extension.
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] sel_fix;
  logic [XLEN-1:0] fix_res;

  always_comb begin
    q_fix   = q_neg_q ? (~quo_q + 1'b1) : quo_q;
    r_fix   = r_neg_q ? (~rem_q + 1'b1) : rem_q;
    sel_fix = rem_sel_q ? r_fix : q_fix;
    fix_res = word_q ? sext32(sel_fix[31:0]) : sel_fix;
  end

  // Hold execute while an op waits in IDLE or iterates; DONE lets the pipeline advance.
  always_comb begin
    stall = ~clear & ((start & (state_q != StDone)) |
                      (state_q == StCalc) | (state_q == StFixup));
  end

  // Control FSM with registered result and done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      rem_sel_q <= 1'b0;
      word_q    <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      result    <= '0;
      done      <= 1'b0;
    end else if (clear) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            rem_sel_q <= op[1];
            word_q    <= word;
            q_neg_q   <= a_neg ^ b_neg;
            r_neg_q   <= a_neg;
            dvs_q     <= b_mag;
            if (div_zero || overflow) begin
              result  <= special_res;
              done    <= 1'b1;
              state_q <= StDone;
            end else if (early_out) begin
              quo_q   <= '0;
              rem_q   <= a_mag;
              state_q <= StFixup;
            end else begin
              quo_q   <= quo_init;
              rem_q   <= '0;
              cnt_q   <= word ? 6'd31 : 6'd63;
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          rem_q <= rem_step;
          quo_q <= quo_step;
          cnt_q <= cnt_q - 6'd1;
          if (cnt_q == 6'd0) begin
            state_q <= StFixup;
          end
        end
        StFixup: begin
          result  <= fix_res;
          done    <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          // The access stage takes the result on the same edge we leave DONE.
          if (!ma_stall) begin
            done    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit. Expected results are queued when an op is issued
// and compared when done rises, together with the completion latency and stall count.

module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic        word = 1'b0;
  logic [63:0] src1 = '0;
  logic [63:0] src2 = '0;
  logic        ma_stall = 1'b0;
  logic        stall;
  logic [63:0] result;
  logic        done;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [63:0] res;
    int          lat;
    string       tag;
  } exp_t;

  exp_t sb[$];

  div_unit #(.XLEN(64)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .start    (start),
    .op       (op),
    .word     (word),
    .src1     (src1),
    .src2     (src2),
    .ma_stall (ma_stall),
    .stall    (stall),
    .result   (result),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, got timeout required completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Reference RISC-V divide semantics.
  function automatic logic [63:0] ref_res(input logic [1:0] o, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32;
    logic [31:0] b32;
    logic [31:0] r32;
    logic [63:0] r64;
    a32 = a[31:0];
    b32 = b[31:0];
    r32 = '0;
    r64 = '0;
    if (w) begin
      if (b32 == 32'd0) r32 = o[1] ? a32 : 32'hFFFF_FFFF;
      else if (!o[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = o[1] ? 32'd0 : a32;
      else begin
        case (o)
          2'd0: r32 = 32'($signed(a32) / $signed(b32));
          2'd1: r32 = a32 / b32;
          2'd2: r32 = 32'($signed(a32) % $signed(b32));
          default: r32 = a32 % b32;
        endcase
      end
      return {{32{r32[31]}}, r32};
    end
    if (b == 64'd0) r64 = o[1] ? a : '1;
    else if (!o[0] && a == 64'h8000_0000_0000_0000 && b == '1) r64 = o[1] ? 64'd0 : a;
    else begin
      case (o)
        2'd0: r64 = 64'($signed(a) / $signed(b));
        2'd1: r64 = a / b;
        2'd2: r64 = 64'($signed(a) % $signed(b));
        default: r64 = a % b;
      endcase
    end
    return r64;
  endfunction

  // Expected cycles from the issuing edge until done is visible (equals stall cycles).
  function automatic int ref_lat(input logic [1:0] o, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    logic [63:0] ax;
    logic [63:0] bx;
    logic [63:0] am;
    logic [63:0] bm;
    logic [63:0] mn;
    logic        sg;
    sg = !o[0];
    ax = a;
    bx = b;
    mn = 64'h8000_0000_0000_0000;
    if (w) begin
      ax = sg ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]};
      bx = sg ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]};
      mn = 64'hFFFF_FFFF_8000_0000;
    end
    if (bx == 64'd0) return 1;
    if (sg && ax == mn && bx == '1) return 1;
    am = (sg && ax[63]) ? -ax : ax;
    bm = (sg && bx[63]) ? -bx : bx;
`ifdef DIV_EARLY_OUT_EN
    if (am < bm) return 2;
`else
    if (am == 64'd0 && bm == 64'd0) return 0;
`endif
    return w ? 34 : 66;
  endfunction

  // Issue one op just after a rising edge, wait for done, score it, optionally hold
  // ma_stall in DONE, then let the pipeline advance.
  task automatic do_op(input logic [1:0] o, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp_res, input int hold,
                       input string tag);
    exp_t e;
    exp_t got;
    int   lat;
    int   stalls;
    logic [63:0] held;
    e.res = exp_res;
    e.lat = ref_lat(o, w, a, b);
    e.tag = tag;
    sb.push_back(e);
    start = 1'b1;
    op    = o;
    word  = w;
    src1  = a;
    src2  = b;
    lat    = 0;
    stalls = 0;
    @(negedge clk);
    while (!done && lat < 100) begin
      if (stall) stalls++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    got = sb.pop_front();
    check_eq({got.tag, "_done"}, 64'(done), 64'd1);
    check_eq({got.tag, "_res"}, result, got.res);
    check_eq({got.tag, "_lat"}, 64'(lat), 64'(got.lat));
    check_eq({got.tag, "_stalls"}, 64'(stalls), 64'(got.lat));
    check_eq({got.tag, "_stall_in_done"}, 64'(stall), 64'd0);
    if (hold > 0) begin
      held = result;
      ma_stall = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        @(negedge clk);
        check_eq({got.tag, "_hold_done"}, 64'(done), 64'd1);
        check_eq({got.tag, "_hold_res"}, result, held);
      end
      ma_stall = 1'b0;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    logic [1:0]  ro;
    logic        rw;
    logic [63:0] ra;
    logic [63:0] rb;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_done", 64'(done), 64'd0);
    check_eq("reset_result", result, 64'd0);
    check_eq("reset_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    do_op(2'd1, 1'b0, 64'd100, 64'd7, 64'd14, 5, "divu_100_7");
    do_op(2'd3, 1'b0, 64'd100, 64'd7, 64'd2, 0, "remu_100_7");
    do_op(2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0, "div_m7_2");
    do_op(2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0, "rem_m7_2");
    do_op(2'd1, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, "divu_by0");
    do_op(2'd2, 1'b1, 64'h0000_0000_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 0, "remw_by0");
    do_op(2'd0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, 0, "div_ovf");
    do_op(2'd2, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, "rem_ovf");
    do_op(2'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 0, "divuw");
    do_op(2'd0, 1'b1, 64'd0, 64'd3, 64'd0, 0, "divw_zero");
`ifdef DIV_EARLY_OUT_EN
    do_op(2'd1, 1'b0, 64'd3, 64'd10, 64'd0, 0, "divu_early");
`endif

    for (int i = 0; i < 12; i++) begin
      ro = 2'($urandom_range(0, 3));
      rw = 1'($urandom_range(0, 1));
      ra = {$urandom, $urandom};
      rb = (i % 3 == 0) ? 64'($urandom_range(1, 20)) : {$urandom, $urandom};
      if (i % 4 == 1) rb = -rb;
      do_op(ro, rw, ra, rb, ref_res(ro, rw, ra, rb), 0, $sformatf("rand%0d", i));
    end

    // Flush mid-iteration: stall must drop in the clear cycle and the unit must go idle.
    start = 1'b1;
    op    = 2'd1;
    word  = 1'b0;
    src1  = 64'd1000;
    src2  = 64'd3;
    repeat (10) @(posedge clk);
    #1;
    clear = 1'b1;
    @(negedge clk);
    check_eq("clear_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_eq("clear_idle_stall", 64'(stall), 64'd0);
    check_eq("clear_idle_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    do_op(2'd1, 1'b0, 64'd1000, 64'd3, 64'd333, 0, "after_clear");

    // Reset mid-iteration: result and done return to zero, done never pulses.
    start = 1'b1;
    op    = 2'd0;
    word  = 1'b0;
    src1  = 64'd77;
    src2  = 64'd5;
    repeat (19) @(posedge clk);
    #1;
    check_eq("pre_reset_done", 64'(done), 64'd0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("midop_reset_result", result, 64'd0);
    check_eq("midop_reset_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    do_op(2'd2, 1'b0, 64'd77, 64'd5, 64'd2, 0, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
